i2s_apb_sched: RTL and testbench



---
 rtl/i2s_apb_sched.sv | 165 ++++++++++++++++
 tb/tb_i2s_apb_sched.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_apb_sched.sv
// rtl/i2s_apb_sched.sv - APB register front end that schedules single Tx/Rx FIFO accesses for an I2S core.
module i2s_apb_sched #(
    parameter int unsigned TIMEOUT  = 16,
    parameter logic [31:0] CTRL_RST = 32'h0000_0000
) (
    input  logic        pclk,
    input  logic        presetn,
    input  logic        psel,
    input  logic        penable,
    input  logic        pwrite,
    input  logic [31:0] paddr,
    input  logic [31:0] pwdata,
    output logic [31:0] prdata,
    output logic        pready,
    output logic        pslverr,
    input  logic        tx_full,
    output logic        tx_wen,
    output logic [31:0] tx_data,
    input  logic        rx_empty,
    output logic        rx_ren,
    input  logic [31:0] rx_data,
    output logic [31:0] controls
);

    localparam logic [31:0] ADDR_TXDATA = 32'h0000_0000;
    localparam logic [31:0] ADDR_CTRL   = 32'h0000_0004;
    localparam logic [31:0] ADDR_RXDATA = 32'h0000_0008;
    localparam logic [31:0] ADDR_STATUS = 32'h0000_000C;
    localparam logic [7:0]  CNT_LAST    = 8'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        TXW  = 3'd1,
        RXR  = 3'd2,
        RXC  = 3'd3,
        RESP = 3'd4
    } state_t;

    state_t      state;
    logic [7:0]  cnt;
    logic        tx_timeout;
    logic        rx_timeout;
    logic [31:0] status;

    assign status = {28'd0, rx_timeout, tx_timeout, rx_empty, tx_full};

    // pslverr doubles as the transfer error flag: it is loaded on the way into RESP
    // so it is only ever seen together with pready.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state      <= IDLE;
            cnt        <= 8'd0;
            prdata     <= 32'd0;
            pready     <= 1'b0;
            pslverr    <= 1'b0;
            tx_wen     <= 1'b0;
            rx_ren     <= 1'b0;
            tx_data    <= 32'd0;
            controls   <= CTRL_RST;
            tx_timeout <= 1'b0;
            rx_timeout <= 1'b0;
        end else begin
            tx_wen <= 1'b0;
            rx_ren <= 1'b0;
            case (state)
                IDLE: begin
                    if (psel && penable && !pready) begin
                        cnt <= 8'd0;
                        case (paddr)
                            ADDR_TXDATA: begin
                                if (pwrite) begin
                                    tx_data <= pwdata;
                                    state   <= TXW;
                                end else begin
                                    state   <= RESP;
                                    pready  <= 1'b1;
                                    pslverr <= 1'b1;
                                end
                            end
                            ADDR_CTRL: begin
                                if (pwrite) begin
                                    controls <= pwdata;
                                end else begin
                                    prdata <= controls;
                                end
                                state   <= RESP;
                                pready  <= 1'b1;
                                pslverr <= 1'b0;
                            end
                            ADDR_RXDATA: begin
                                if (!pwrite) begin
                                    state <= RXR;
                                end else begin
                                    state   <= RESP;
                                    pready  <= 1'b1;
                                    pslverr <= 1'b1;
                                end
                            end
                            ADDR_STATUS: begin
                                if (pwrite) begin
                                    if (pwdata[2]) tx_timeout <= 1'b0;
                                    if (pwdata[3]) rx_timeout <= 1'b0;
                                end else begin
                                    prdata <= status;
                                end
                                state   <= RESP;
                                pready  <= 1'b1;
                                pslverr <= 1'b0;
                            end
                            default: begin
                                state   <= RESP;
                                pready  <= 1'b1;
                                pslverr <= 1'b1;
                            end
                        endcase
                    end
                end
                TXW: begin
                    if (!tx_full) begin
                        tx_wen  <= 1'b1;
                        state   <= RESP;
                        pready  <= 1'b1;
                        pslverr <= 1'b0;
                    end else if (cnt == CNT_LAST) begin
                        tx_timeout <= 1'b1;
                        state      <= RESP;
                        pready     <= 1'b1;
                        pslverr    <= 1'b1;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                RXR: begin
                    if (!rx_empty) begin
                        rx_ren <= 1'b1;
                        state  <= RXC;
                    end else if (cnt == CNT_LAST) begin
                        rx_timeout <= 1'b1;
                        prdata     <= 32'd0;
                        state      <= RESP;
                        pready     <= 1'b1;
                        pslverr    <= 1'b1;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                RXC: begin
                    prdata  <= rx_data;
                    state   <= RESP;
                    pready  <= 1'b1;
                    pslverr <= 1'b0;
                end
                RESP: begin
                    pready  <= 1'b0;
                    pslverr <= 1'b0;
                    state   <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2s_apb_sched.sv
// tb/tb_i2s_apb_sched.sv - self-checking bench for i2s_apb_sched with directed and randomized APB traffic.
module tb_i2s_apb_sched;

    localparam int          T    = 6;
    localparam logic [31:0] CRST = 32'h0000_00A5;

    logic        pclk = 1'b0;
    logic        presetn;
    logic        psel, penable, pwrite;
    logic [31:0] paddr, pwdata, prdata;
    logic        pready, pslverr;
    logic        tx_full, tx_wen;
    logic [31:0] tx_data;
    logic        rx_empty, rx_ren;
    logic [31:0] rx_data, controls;

    int          n_chk = 0;
    int          n_fail = 0;
    int          wen_cnt = 0;
    int          ren_cnt = 0;
    logic [31:0] wen_q[$];

    i2s_apb_sched #(.TIMEOUT(T), .CTRL_RST(CRST)) dut (
        .pclk(pclk), .presetn(presetn), .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr),
        .tx_full(tx_full), .tx_wen(tx_wen), .tx_data(tx_data), .rx_empty(rx_empty),
        .rx_ren(rx_ren), .rx_data(rx_data), .controls(controls)
    );

    always #5 pclk = ~pclk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    always @(negedge pclk) begin
        if (tx_wen) begin
            wen_cnt++;
            wen_q.push_back(tx_data);
        end
        if (rx_ren) ren_cnt++;
        if (tx_wen || rx_ren) chk("strobe_exclusive", {31'd0, tx_wen && rx_ren}, 32'd0);
    end

    // lat = clock edges from the setup edge to the edge on which the bus samples pready
    task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] rd, output logic err, output int lat);
        @(negedge pclk);
        psel = 1'b1; penable = 1'b0; pwrite = w; paddr = a; pwdata = d;
        @(posedge pclk);
        @(negedge pclk);
        penable = 1'b1;
        lat = 1;
        while (1) begin
            @(posedge pclk);
            lat++;
            @(negedge pclk);
            if (pready || lat > 200) break;
        end
        rd  = prdata;
        err = pslverr;
        @(posedge pclk);
        @(negedge pclk);
        psel = 1'b0; penable = 1'b0;
        chk("pready_one_cycle", {31'd0, pready}, 32'd0);
    endtask

    logic [31:0] rd, d, a, m_ctrl, m_prdata, exp_rd;
    logic        er, m_txto, m_rxto, exp_err, blk;
    int          lat, exp_lat, w0, r0, exp_w, exp_r, op;

    initial begin
        presetn = 1'b0; psel = 0; penable = 0; pwrite = 0; paddr = 0; pwdata = 0;
        tx_full = 0; rx_empty = 0; rx_data = 0;
        #12;
        chk("rst_prdata", prdata, 32'd0);
        chk("rst_pready", {31'd0, pready}, 32'd0);
        chk("rst_controls", controls, CRST);
        chk("rst_tx_data", tx_data, 32'd0);
        @(negedge pclk);
        presetn = 1'b1;

        // CTRL write then read
        xfer(1, 32'h4, 32'h0000_1A85, rd, er, lat);
        chk("ctrl_wr_lat", lat, 2);
        chk("ctrl_wr_err", {31'd0, er}, 0);
        chk("ctrl_value", controls, 32'h0000_1A85);
        xfer(0, 32'h4, 32'h0, rd, er, lat);
        chk("ctrl_rd_lat", lat, 2);
        chk("ctrl_rd_data", rd, 32'h0000_1A85);

        // unblocked TX
        w0 = wen_cnt;
        xfer(1, 32'h0, 32'hDEAD_BEEF, rd, er, lat);
        chk("tx_lat", lat, 3);
        chk("tx_err", {31'd0, er}, 0);
        chk("tx_wen_count", wen_cnt - w0, 1);
        if (wen_q.size() > 0) chk("tx_wen_data", wen_q.pop_back(), 32'hDEAD_BEEF);

        // blocked TX times out
        tx_full = 1; w0 = wen_cnt;
        xfer(1, 32'h0, 32'h1111_2222, rd, er, lat);
        chk("txblk_lat", lat, T + 2);
        chk("txblk_err", {31'd0, er}, 1);
        chk("txblk_no_wen", wen_cnt - w0, 0);
        tx_full = 0;
        xfer(0, 32'hC, 32'h0, rd, er, lat);
        chk("status_txto", rd, 32'h4);
        xfer(1, 32'hC, 32'h4, rd, er, lat);
        xfer(0, 32'hC, 32'h0, rd, er, lat);
        chk("status_cleared", rd, 32'h0);

        // RX unblocked then blocked
        rx_data = 32'h1234_5678; r0 = ren_cnt;
        xfer(0, 32'h8, 32'h0, rd, er, lat);
        chk("rx_lat", lat, 4);
        chk("rx_data", rd, 32'h1234_5678);
        chk("rx_ren_count", ren_cnt - r0, 1);
        rx_empty = 1; r0 = ren_cnt;
        xfer(0, 32'h8, 32'h0, rd, er, lat);
        chk("rxblk_data", rd, 32'h0);
        chk("rxblk_err", {31'd0, er}, 1);
        chk("rxblk_no_ren", ren_cnt - r0, 0);
        rx_empty = 0;
        xfer(0, 32'hC, 32'h0, rd, er, lat);
        chk("status_rxto", rd, 32'h8);
        xfer(1, 32'hC, 32'h8, rd, er, lat);

        // unmapped read, then reset during a TXW wait
        xfer(0, 32'h10, 32'h0, rd, er, lat);
        chk("bad_addr_err", {31'd0, er}, 1);
        chk("bad_addr_ctrl_held", controls, 32'h0000_1A85);
        tx_full = 1; w0 = wen_cnt;
        @(negedge pclk);
        psel = 1; penable = 0; pwrite = 1; paddr = 32'h0; pwdata = 32'hCAFE_F00D;
        @(posedge pclk);
        @(negedge pclk);
        penable = 1;
        repeat (3) @(negedge pclk);
        #2 presetn = 1'b0;
        #1;
        chk("mid_rst_pready", {31'd0, pready}, 0);
        chk("mid_rst_pslverr", {31'd0, pslverr}, 0);
        chk("mid_rst_prdata", prdata, 0);
        chk("mid_rst_tx_data", tx_data, 0);
        chk("mid_rst_controls", controls, CRST);
        psel = 0; penable = 0; tx_full = 0;
        @(negedge pclk);
        presetn = 1'b1;
        repeat (10) @(negedge pclk);
        chk("mid_rst_no_wen", wen_cnt - w0, 0);
        xfer(0, 32'hC, 32'h0, rd, er, lat);
        chk("post_rst_status", rd, 32'h0);

        // randomized traffic against the reference model
        m_ctrl = CRST; m_txto = 0; m_rxto = 0; m_prdata = rd;
        for (int i = 0; i < 60; i++) begin
            op = $urandom_range(0, 6);
            d = $urandom;
            blk = ($urandom_range(0, 3) == 0);
            tx_full = $urandom_range(0, 1);
            rx_empty = $urandom_range(0, 1);
            rx_data = $urandom;
            exp_err = 0; exp_lat = 2; exp_w = 0; exp_r = 0;
            w0 = wen_cnt; r0 = ren_cnt;
            case (op)
                0: begin
                    xfer(1, 32'h4, d, rd, er, lat);
                    m_ctrl = d;
                end
                1: begin
                    xfer(0, 32'h4, d, rd, er, lat);
                    m_prdata = m_ctrl;
                end
                2: begin
                    m_prdata = 32'(m_rxto) * 8 + 32'(m_txto) * 4 + 32'(rx_empty) * 2 + 32'(tx_full);
                    xfer(0, 32'hC, d, rd, er, lat);
                end
                3: begin
                    xfer(1, 32'hC, d, rd, er, lat);
                    if (d[2]) m_txto = 0;
                    if (d[3]) m_rxto = 0;
                end
                4: begin
                    tx_full = blk;
                    xfer(1, 32'h0, d, rd, er, lat);
                    if (blk) begin
                        exp_err = 1; exp_lat = T + 2; m_txto = 1;
                    end else begin
                        exp_lat = 3; exp_w = 1;
                    end
                end
                5: begin
                    rx_empty = blk;
                    xfer(0, 32'h8, d, rd, er, lat);
                    if (blk) begin
                        exp_err = 1; exp_lat = T + 2; m_rxto = 1; m_prdata = 0;
                    end else begin
                        exp_lat = 4; exp_r = 1; m_prdata = rx_data;
                    end
                end
                default: begin
                    case ($urandom_range(0, 2))
                        0: xfer(0, 32'h0, d, rd, er, lat);
                        1: xfer(1, 32'h8, d, rd, er, lat);
                        default: begin
                            a = {20'd0, 8'($urandom_range(1, 255)), 4'h0};
                            xfer($urandom_range(0, 1) == 1, a, d, rd, er, lat);
                        end
                    endcase
                    exp_err = 1;
                end
            endcase
            exp_rd = m_prdata;
            chk("rnd_err", {31'd0, er}, {31'd0, exp_err});
            chk("rnd_lat", lat, exp_lat);
            chk("rnd_prdata", rd, exp_rd);
            chk("rnd_controls", controls, m_ctrl);
            chk("rnd_wen_count", wen_cnt - w0, exp_w);
            chk("rnd_ren_count", ren_cnt - r0, exp_r);
            if (exp_w == 1 && wen_q.size() > 0) chk("rnd_tx_data", wen_q.pop_back(), d);
        end
        tx_full = 0; rx_empty = 0;
        xfer(0, 32'hC, 32'h0, rd, er, lat);
        chk("final_status", rd, 32'(m_rxto) * 8 + 32'(m_txto) * 4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
